flick_scheduler: RTL and testbench
==================================

# flick_scheduler

Front-end controller for `bound_flasher` that shares its single `flick` input between several requesters. It runs a round-robin arbiter and drives a clean, fixed-width flick pulse into an idle flasher. It then watches `led_state` until the flash sequence returns to all-off, and reports completion or a start failure back to the granted requester. It sits between the requester logic (buttons, timers, host) and one `bound_flasher` instance.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8).
- `HOLD_CYCLES`, 3, cycles `flick` is held high per grant (1..15).
- `START_TIMEOUT`, 8, max cycles in RUN without `led_state != 0` before abort (1..255).
- `IDLE_GAP`, 2, cycles of enforced idle after each run (0..15).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  level request per requester.
- `led_state`  in  16  flasher output, monitored.
- `flick`  out  1  to `bound_flasher.flick`.
- `grant`  out  NUM_REQ  one-hot, owner of current run, 0 when none.
- `done`  out  NUM_REQ  one-cycle pulse to owner on normal completion.
- `err`  out  1  one-cycle pulse on start timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FLICK, RUN, GAP.
- IDLE → FLICK:
  - Condition: `req != 0` and `led_state == 0`.
  - The winner is the lowest index at or after the round-robin pointer, wrapping.
  - The pointer becomes winner+1 mod NUM_REQ.
  - `grant` is loaded and held until the run completes or aborts.
- IDLE with `req != 0` but `led_state != 0` (flasher not at rest): stay in IDLE, no grant.
- FLICK:
  - `flick=1` for exactly HOLD_CYCLES cycles, then go to RUN.
  - If `led_state != 0` is seen during FLICK, set the `seen_on` flag.
- RUN:
  - `flick=0` throughout. No flick is ever issued mid-sequence, so the flasher never kicks back.
  - Set `seen_on` when `led_state != 0`.
  - Completion: `seen_on==1` and `led_state == 0`. Then pulse `done[owner]`, clear `grant` and `seen_on`, go to GAP.
  - Abort: `seen_on==0` after START_TIMEOUT RUN cycles. Then pulse `err`, clear `grant`, go to GAP. `done` stays low.
- GAP: wait IDLE_GAP cycles, then go to IDLE. With IDLE_GAP=0, GAP lasts 1 cycle.
- A requester dropping `req` after grant does not cancel the run; that owner still gets `done`.
- A new `req` that arrives during FLICK, RUN or GAP is held by the requester and arbitrated in the next IDLE.
- One shared down-counter serves FLICK, RUN and GAP. Its width is $clog2(max(HOLD_CYCLES, START_TIMEOUT, IDLE_GAP)+1). It is loaded on each state entry.

## Timing
- Reset values: `flick=0`, `grant=0`, `done=0`, `err=0`, `busy=0`, state=IDLE, pointer=0, `seen_on=0`, counter=0.
- Reset mid-operation: all of the above clear immediately, asynchronously. `flick` drops in the same instant.
- All outputs are registered.
- Request latency: `req` sampled high in IDLE at edge N gives `grant` and `flick` high after edge N+1.
- `flick` high for edges N+1 .. N+HOLD_CYCLES, low from edge N+HOLD_CYCLES+1.
- `done` or `err` and the `grant` drop occur on the same edge, one cycle after the first sampled `led_state==0` with `seen_on` set (or after timeout).
- Next grant no earlier than IDLE_GAP+2 edges after `done`.
- `led_state` is used directly; it is synchronous to `clk`, so no synchronizer.

## Structure
- Shared package `flasher_pkg`:
  - `LED_W = 16`.
  - State enum `fs_state_t` {IDLE, FLICK, RUN, GAP}.
  - Default parameter constants.
- Sub-module `rr_arbiter`:
  - Parameter NUM_REQ.
  - Inputs `req` and `ptr`; output one-hot `gnt` (combinational).
  - The pointer register lives in `flick_scheduler`.

## Test plan
- Reset release, `req=0`: all outputs 0 indefinitely; assert `rst_n` low mid-RUN → `flick`, `grant` and `busy` clear asynchronously.
- `req=4'b0001` with flasher attached: `grant=0001`, `flick` high 3 cycles, flasher runs its full sequence, `done=0001` one-cycle pulse when `led_state` returns to 0, `busy` low after 2 GAP cycles +1.
- `req=4'b1111` held: grants in order 0001, 0010, 0100, 1000, 0001, each run ending in `done`, no overlap.
- `led_state` stub held at 0 (no flasher): `err` pulses 8 cycles after RUN entry, `done` stays 0, then next requester is granted.
- `req[2]` dropped one cycle after grant: run still completes and `done=0100` pulses; `flick` stays 0 for the entire RUN, checked every cycle.
- `led_state` stub forced to 16'h0003 while `req=0001`: no grant until the stub returns to 0, then grant on the following edge.

Source files
------------

// File: rtl/flasher_pkg.sv
// Shared types and defaults for the bound_flasher front-end scheduler.
package flasher_pkg;

   localparam int LED_W             = 16;
   localparam int DEF_NUM_REQ       = 4;
   localparam int DEF_HOLD_CYCLES   = 3;
   localparam int DEF_START_TIMEOUT = 8;
   localparam int DEF_IDLE_GAP      = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLICK = 2'd1,
      RUN   = 2'd2,
      GAP   = 2'd3
   } fs_state_t;

   // Sizes the shared down-counter so it holds the longest of the three phases.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic             w_found;
   logic [PTR_W-1:0] w_sel;

   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel = PTR_W'((int'(ptr) + i) % NUM_REQ);
         if (!w_found && req[w_sel]) begin
            gnt[w_sel] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/flick_scheduler.sv
// Shares one bound_flasher between NUM_REQ requesters: arbitrates, issues a fixed-width
// flick pulse, then tracks led_state until the sequence returns to all-off.
module flick_scheduler
   import flasher_pkg::*;
#(
   parameter int NUM_REQ       = DEF_NUM_REQ,
   parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int IDLE_GAP      = DEF_IDLE_GAP
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic [LED_W-1:0]   led_state,
   output logic               flick,
   output logic [NUM_REQ-1:0] grant,
   output logic [NUM_REQ-1:0] done,
   output logic               err,
   output logic               busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(max3(HOLD_CYCLES, START_TIMEOUT, IDLE_GAP) + 1);

   localparam logic [CNT_W-1:0] LD_HOLD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] LD_RUN  = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(IDLE_GAP);

   fs_state_t          r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_seen_on;
   logic               r_flick;
   logic [NUM_REQ-1:0] r_grant;
   logic [NUM_REQ-1:0] r_done;
   logic               r_err;
   logic               r_busy;

   logic [NUM_REQ-1:0] w_gnt;
   logic [PTR_W-1:0]   w_win;
   logic [PTR_W-1:0]   w_ptr_nxt;
   logic               w_led_on;
   logic               w_seen_nxt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req (req),
      .ptr (r_ptr),
      .gnt (w_gnt)
   );

   assign w_led_on   = |led_state;
   assign w_seen_nxt = r_seen_on | w_led_on;

   always_comb begin
      w_win = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) w_win = PTR_W'(i);
      end
      w_ptr_nxt = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_cnt     <= '0;
         r_seen_on <= 1'b0;
         r_flick   <= 1'b0;
         r_grant   <= '0;
         r_done    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_done <= '0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               // A flasher still mid-sequence would misread a new flick, so wait for rest.
               if ((|req) && !w_led_on) begin
                  r_state   <= FLICK;
                  r_grant   <= w_gnt;
                  r_ptr     <= w_ptr_nxt;
                  r_flick   <= 1'b1;
                  r_busy    <= 1'b1;
                  r_seen_on <= 1'b0;
                  r_cnt     <= LD_HOLD;
               end
            end
            FLICK: begin
               r_seen_on <= w_seen_nxt;
               if (r_cnt == '0) begin
                  r_state <= RUN;
                  r_flick <= 1'b0;
                  r_cnt   <= LD_RUN;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            RUN: begin
               if (r_seen_on && !w_led_on) begin
                  r_done    <= r_grant;
                  r_grant   <= '0;
                  r_seen_on <= 1'b0;
                  r_state   <= GAP;
                  r_cnt     <= LD_GAP;
               end else if ((r_cnt == '0) && !w_seen_nxt) begin
                  r_err     <= 1'b1;
                  r_grant   <= '0;
                  r_seen_on <= 1'b0;
                  r_state   <= GAP;
                  r_cnt     <= LD_GAP;
               end else begin
                  r_seen_on <= w_seen_nxt;
                  if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            GAP: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign flick = r_flick;
   assign grant = r_grant;
   assign done  = r_done;
   assign err   = r_err;
   assign busy  = r_busy;

endmodule

// File: tb/tb_flick_scheduler.sv
// Scoreboard bench for flick_scheduler with a small behavioural flasher stub.
module tb_flick_scheduler;

   localparam int NR   = 4;
   localparam int HOLD = 3;
   localparam int TO   = 8;
   localparam int GAP  = 2;

   typedef struct {
      logic [NR-1:0] done;
      logic          err;
      int            lat;
   } end_t;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [NR-1:0] req   = '0;
   logic [15:0]   led_state;
   logic          flick;
   logic [NR-1:0] grant;
   logic [NR-1:0] done;
   logic          err;
   logic          busy;

   logic [15:0] led_model;
   int          fl_cnt;
   bit          model_en  = 1'b1;
   bit          force_en  = 1'b0;
   logic [15:0] force_val = '0;

   int n_cmp    = 0;
   int n_err    = 0;
   int n_grants = 0;
   int n_ends   = 0;

   logic [NR-1:0] exp_grant_q[$];
   end_t          exp_end_q[$];

   flick_scheduler #(
      .NUM_REQ       (NR),
      .HOLD_CYCLES   (HOLD),
      .START_TIMEOUT (TO),
      .IDLE_GAP      (GAP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .led_state (led_state),
      .flick     (flick),
      .grant     (grant),
      .done      (done),
      .err       (err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Flasher stub: lit for six cycles after seeing flick, then back to all-off.
   assign led_state = force_en ? force_val : led_model;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_model <= '0;
         fl_cnt    <= 0;
      end else if (fl_cnt > 1) begin
         fl_cnt    <= fl_cnt - 1;
         led_model <= {led_model[14:0], 1'b1};
      end else if (fl_cnt == 1) begin
         fl_cnt    <= 0;
         led_model <= '0;
      end else if (flick && model_en) begin
         fl_cnt    <= 6;
         led_model <= 16'h0001;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_grants(input int target);
      for (int i = 0; i < 400; i++) begin
         if (n_grants >= target) break;
         @(negedge clk);
      end
      chk("wait_grant", 32'(n_grants >= target), 32'd1);
   endtask

   task automatic wait_ends(input int target);
      for (int i = 0; i < 400; i++) begin
         if (n_ends >= target) break;
         @(negedge clk);
      end
      chk("wait_end", 32'(n_ends >= target), 32'd1);
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      #2;
   endtask

   // Monitor: pops expectations whenever the DUT presents a grant or a completion.
   initial begin
      logic [NR-1:0] prev_grant;
      logic [NR-1:0] cur_grant;
      logic [NR-1:0] eg;
      end_t          ee;
      bit            run_active;
      bit            flick_fall;
      bit            post_active;
      int            post_cnt;
      int            flick_cnt;
      int            cyc;
      prev_grant  = '0;
      cur_grant   = '0;
      run_active  = 1'b0;
      flick_fall  = 1'b0;
      post_active = 1'b0;
      post_cnt    = 0;
      flick_cnt   = 0;
      cyc         = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            run_active  = 1'b0;
            post_active = 1'b0;
            flick_fall  = 1'b0;
            flick_cnt   = 0;
            prev_grant  = '0;
         end else begin
            if (post_active) begin
               post_cnt++;
               if (post_cnt == 1) chk("pulse_width", 32'({done, err}), 32'd0);
               if (post_cnt <= GAP) begin
                  chk("busy_in_gap", 32'({busy, grant}), 32'({1'b1, 4'b0000}));
               end else begin
                  chk("busy_after_gap", 32'(busy), 32'd0);
                  post_active = 1'b0;
               end
            end
            if (run_active) begin
               cyc++;
               if (flick_fall) chk("flick_low_run", 32'(flick), 32'd0);
               if (flick && !flick_fall) begin
                  flick_cnt++;
               end else if (!flick && !flick_fall) begin
                  flick_fall = 1'b1;
                  chk("flick_width", flick_cnt, HOLD);
               end
               if (grant != '0) chk("grant_hold", 32'(grant), 32'(cur_grant));
            end
            if ((done != '0) || err) begin
               n_ends++;
               if (exp_end_q.size() == 0) begin
                  chk("unexpected_end", 32'({done, err}), 32'd0);
               end else begin
                  ee = exp_end_q.pop_front();
                  chk("end_done", 32'(done), 32'(ee.done));
                  chk("end_err", 32'(err), 32'(ee.err));
                  chk("end_latency", cyc, ee.lat);
                  chk("grant_clear", 32'(grant), 32'd0);
               end
               run_active  = 1'b0;
               post_active = 1'b1;
               post_cnt    = 0;
            end
            if ((prev_grant == '0) && (grant != '0)) begin
               n_grants++;
               if (exp_grant_q.size() == 0) begin
                  chk("unexpected_grant", 32'(grant), 32'd0);
                  cur_grant = grant;
               end else begin
                  eg = exp_grant_q.pop_front();
                  chk("grant_order", 32'(grant), 32'(eg));
                  cur_grant = eg;
               end
               run_active = 1'b1;
               cyc        = 0;
               flick_cnt  = flick ? 1 : 0;
               flick_fall = 1'b0;
            end
            prev_grant = grant;
         end
      end
   end

   // Stimulus
   initial begin
      rst_n = 1'b0;
      req   = '0;
      #2 chk("reset_outputs", 32'({flick, grant, done, err, busy}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", 32'({flick, grant, done, err, busy}), 32'd0);
      end

      // Single requester with flasher attached; pointer ends at 1.
      exp_grant_q.push_back(4'b0001);
      exp_end_q.push_back('{4'b0001, 1'b0, 8});
      @(posedge clk); #2 req = 4'b0001;
      wait_grants(1);
      @(posedge clk); #2 req = '0;
      wait_ends(1);
      settle();

      // Reset pulled mid-RUN; pointer returns to 0.
      exp_grant_q.push_back(4'b0001);
      @(posedge clk); #2 req = 4'b0001;
      wait_grants(2);
      repeat (5) @(posedge clk);
      #2 req = '0;
      rst_n = 1'b0;
      #1 chk("async_reset", 32'({flick, grant, busy, done, err}), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      settle();

      // All four requesting: strict rotation from index 0.
      exp_grant_q.push_back(4'b0001);
      exp_grant_q.push_back(4'b0010);
      exp_grant_q.push_back(4'b0100);
      exp_grant_q.push_back(4'b1000);
      exp_grant_q.push_back(4'b0001);
      for (int i = 0; i < 4; i++) exp_end_q.push_back('{4'b0001 << i, 1'b0, 8});
      exp_end_q.push_back('{4'b0001, 1'b0, 8});
      @(posedge clk); #2 req = 4'b1111;
      wait_grants(7);
      @(posedge clk); #2 req = '0;
      wait_ends(6);
      settle();

      // No flasher: start timeout, then the next requester (ptr=2 wraps to 0).
      model_en = 1'b0;
      exp_grant_q.push_back(4'b0010);
      exp_grant_q.push_back(4'b0001);
      exp_end_q.push_back('{4'b0000, 1'b1, HOLD + TO});
      exp_end_q.push_back('{4'b0000, 1'b1, HOLD + TO});
      @(posedge clk); #2 req = 4'b0011;
      wait_grants(9);
      @(posedge clk); #2 req = '0;
      wait_ends(8);
      model_en = 1'b1;
      settle();

      // Owner drops req one cycle after grant; run must still complete.
      exp_grant_q.push_back(4'b0100);
      exp_end_q.push_back('{4'b0100, 1'b0, 8});
      @(posedge clk); #2 req = 4'b0100;
      wait_grants(10);
      @(posedge clk); #2 req = '0;
      wait_ends(9);
      settle();

      // Flasher not at rest: request blocked until led_state returns to 0.
      @(posedge clk); #2;
      force_val = 16'h0003;
      force_en  = 1'b1;
      req       = 4'b0001;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #3;
         chk("blocked_grant", 32'({grant, busy}), 32'd0);
      end
      exp_grant_q.push_back(4'b0001);
      exp_end_q.push_back('{4'b0001, 1'b0, 8});
      @(posedge clk); #2 force_en = 1'b0;
      @(posedge clk); #1 chk("release_grant", 32'(grant), 32'(4'b0001));
      req = '0;
      wait_grants(11);
      wait_ends(10);
      settle();

      chk("grant_queue_empty", exp_grant_q.size(), 0);
      chk("end_queue_empty", exp_end_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
